// File: rtl/ddr_cmd_engine.sv
// Bridge-to-MIG command engine: single/burst 32-bit read/write over the 7-series native app interface.
// Optional macro RD_TIMEOUT_EN adds a read-return watchdog and a sticky rd_timeout output.
module ddr_cmd_engine #(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned APP_DATA_W = 128
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cmd_vld,
  input  logic                      cmd,
  input  logic [31:0]               addr,
  input  logic [7:0]                blen,
  input  logic [31:0]               data_i,
  output logic                      wdata_next,
  output logic [7:0]                tg_state,
  output logic                      cmd_cmptd,
  output logic [31:0]               rdata,
  output logic                      rdata_vld,
  input  logic                      init_calib_complete,
  output logic                      app_en,
  output logic [2:0]                app_cmd,
  output logic [ADDR_W-1:0]         app_addr,
  input  logic                      app_rdy,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [APP_DATA_W-1:0]     app_wdf_data,
  output logic [APP_DATA_W/8-1:0]   app_wdf_mask,
  input  logic                      app_wdf_rdy,
  input  logic [APP_DATA_W-1:0]     app_rd_data,
  input  logic                      app_rd_data_valid
`ifdef RD_TIMEOUT_EN
  ,
  output logic                      rd_timeout
`endif
);

  localparam int unsigned LANES  = APP_DATA_W / 32;
  localparam int unsigned MASK_W = APP_DATA_W / 8;
  localparam int unsigned CNT_W  = 9;
  localparam int unsigned TMO_W  = 16;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  // Write sub-phases: run the beat, pulse wdata_next, then sample the next data_i.
  localparam logic [1:0] WP_RUN  = 2'd0;
  localparam logic [1:0] WP_NEXT = 2'd1;
  localparam logic [1:0] WP_LOAD = 2'd2;

  typedef enum logic [7:0] {
    S_CALIB = 8'h01,
    S_IDLE  = 8'h02,
    S_WR    = 8'h04,
    S_RD    = 8'h20,
    S_DONE  = 8'h40
  } state_t;

  state_t                r_state, w_state_n;
  logic [31:0]           r_addr, w_addr_n;
  logic [31:0]           r_raddr, w_raddr_n;
  logic [7:0]            r_blen, w_blen_n;
  logic [7:0]            r_bcnt, w_bcnt_n;
  logic [CNT_W-1:0]      r_icnt, w_icnt_n;
  logic [CNT_W-1:0]      r_rcnt, w_rcnt_n;
  logic [1:0]            r_wphase, w_wphase_n;
  logic                  r_app_en, w_app_en_n;
  logic [2:0]            r_app_cmd, w_app_cmd_n;
  logic [ADDR_W-1:0]     r_app_addr, w_app_addr_n;
  logic                  r_wren, w_wren_n;
  logic [APP_DATA_W-1:0] r_wdf_data, w_wdf_data_n;
  logic [MASK_W-1:0]     r_wdf_mask, w_wdf_mask_n;
  logic                  r_wdata_next, w_wdata_next_n;
  logic                  r_cmptd, w_cmptd_n;
  logic [31:0]           r_rdata, w_rdata_n;
  logic                  r_rdata_vld, w_rdata_vld_n;
`ifdef RD_TIMEOUT_EN
  logic [TMO_W-1:0]      r_tmo, w_tmo_n;
  logic                  r_rd_timeout, w_rd_timeout_n;
`endif

  logic [31:0] w_addr_inc;
  logic [31:0] w_raddr_inc;
  assign w_addr_inc  = r_addr + 32'd4;
  assign w_raddr_inc = r_raddr + 32'd4;

  // app_addr is the byte address halved with the 128-bit column bits cleared.
  function automatic logic [ADDR_W-1:0] f_app_addr(input logic [ADDR_W-4:0] hi);
    f_app_addr = {hi, 3'b000};
  endfunction

  function automatic logic [MASK_W-1:0] f_mask(input logic [1:0] lane);
    f_mask = '1;
    for (int l = 0; l < LANES; l++)
      if (lane == 2'(l)) f_mask[l*4 +: 4] = 4'h0;
  endfunction

  function automatic logic [31:0] f_lane(input logic [APP_DATA_W-1:0] d, input logic [1:0] lane);
    f_lane = '0;
    for (int l = 0; l < LANES; l++)
      if (lane == 2'(l)) f_lane = d[l*32 +: 32];
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= S_CALIB;
      r_addr       <= '0;
      r_raddr      <= '0;
      r_blen       <= '0;
      r_bcnt       <= '0;
      r_icnt       <= '0;
      r_rcnt       <= '0;
      r_wphase     <= WP_RUN;
      r_app_en     <= 1'b0;
      r_app_cmd    <= 3'b000;
      r_app_addr   <= '0;
      r_wren       <= 1'b0;
      r_wdf_data   <= '0;
      r_wdf_mask   <= '0;
      r_wdata_next <= 1'b0;
      r_cmptd      <= 1'b0;
      r_rdata      <= '0;
      r_rdata_vld  <= 1'b0;
`ifdef RD_TIMEOUT_EN
      r_tmo        <= '0;
      r_rd_timeout <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_addr       <= w_addr_n;
      r_raddr      <= w_raddr_n;
      r_blen       <= w_blen_n;
      r_bcnt       <= w_bcnt_n;
      r_icnt       <= w_icnt_n;
      r_rcnt       <= w_rcnt_n;
      r_wphase     <= w_wphase_n;
      r_app_en     <= w_app_en_n;
      r_app_cmd    <= w_app_cmd_n;
      r_app_addr   <= w_app_addr_n;
      r_wren       <= w_wren_n;
      r_wdf_data   <= w_wdf_data_n;
      r_wdf_mask   <= w_wdf_mask_n;
      r_wdata_next <= w_wdata_next_n;
      r_cmptd      <= w_cmptd_n;
      r_rdata      <= w_rdata_n;
      r_rdata_vld  <= w_rdata_vld_n;
`ifdef RD_TIMEOUT_EN
      r_tmo        <= w_tmo_n;
      r_rd_timeout <= w_rd_timeout_n;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n      = r_state;
    w_addr_n       = r_addr;
    w_raddr_n      = r_raddr;
    w_blen_n       = r_blen;
    w_bcnt_n       = r_bcnt;
    w_icnt_n       = r_icnt;
    w_rcnt_n       = r_rcnt;
    w_wphase_n     = r_wphase;
    w_app_en_n     = r_app_en;
    w_app_cmd_n    = r_app_cmd;
    w_app_addr_n   = r_app_addr;
    w_wren_n       = r_wren;
    w_wdf_data_n   = r_wdf_data;
    w_wdf_mask_n   = r_wdf_mask;
    w_wdata_next_n = 1'b0;
    w_cmptd_n      = 1'b0;
    w_rdata_n      = r_rdata;
    w_rdata_vld_n  = 1'b0;
`ifdef RD_TIMEOUT_EN
    w_tmo_n        = r_tmo;
    w_rd_timeout_n = r_rd_timeout;
`endif

    case (r_state)
      S_CALIB: begin
        if (init_calib_complete) begin
          w_state_n = S_IDLE;
          w_cmptd_n = 1'b1;
        end
      end

      S_IDLE: begin
        if (!init_calib_complete) begin
          w_state_n = S_CALIB;
        end else if (cmd_vld) begin
          w_addr_n     = addr;
          w_raddr_n    = addr;
          w_blen_n     = blen;
          w_bcnt_n     = '0;
          w_icnt_n     = '0;
          w_rcnt_n     = '0;
          w_wphase_n   = WP_RUN;
          w_app_en_n   = 1'b1;
          w_app_addr_n = f_app_addr(addr[ADDR_W:4]);
`ifdef RD_TIMEOUT_EN
          w_tmo_n      = '0;
`endif
          if (cmd) begin
            w_state_n    = S_WR;
            w_app_cmd_n  = CMD_WR;
            w_wren_n     = 1'b1;
            w_wdf_data_n = {LANES{data_i}};
            w_wdf_mask_n = f_mask(addr[3:2]);
          end else begin
            w_state_n    = S_RD;
            w_app_cmd_n  = CMD_RD;
          end
        end
      end

      S_WR: begin
        case (r_wphase)
          WP_RUN: begin
            // Command and data halves retire independently; the beat ends when both have gone.
            w_app_en_n = r_app_en & ~app_rdy;
            w_wren_n   = r_wren & ~app_wdf_rdy;
            if (!w_app_en_n && !w_wren_n) begin
              if (r_bcnt == r_blen) begin
                w_state_n = S_DONE;
              end else begin
                w_bcnt_n       = r_bcnt + 8'd1;
                w_addr_n       = w_addr_inc;
                w_wdata_next_n = 1'b1;
                w_wphase_n     = WP_NEXT;
              end
            end
          end
          WP_NEXT: w_wphase_n = WP_LOAD;
          default: begin
            w_wphase_n   = WP_RUN;
            w_app_en_n   = 1'b1;
            w_wren_n     = 1'b1;
            w_app_addr_n = f_app_addr(r_addr[ADDR_W:4]);
            w_wdf_data_n = {LANES{data_i}};
            w_wdf_mask_n = f_mask(r_addr[3:2]);
          end
        endcase
      end

      S_RD: begin
        if (r_app_en && app_rdy) begin
          w_icnt_n     = r_icnt + CNT_W'(1);
          w_addr_n     = w_addr_inc;
          w_app_addr_n = f_app_addr(w_addr_inc[ADDR_W:4]);
          if (r_icnt == CNT_W'(r_blen)) w_app_en_n = 1'b0;
        end
        if (app_rd_data_valid) begin
          w_rdata_n     = f_lane(app_rd_data, r_raddr[3:2]);
          w_rdata_vld_n = 1'b1;
          w_raddr_n     = w_raddr_inc;
          w_rcnt_n      = r_rcnt + CNT_W'(1);
`ifdef RD_TIMEOUT_EN
          w_tmo_n       = '0;
`endif
          if (r_rcnt == CNT_W'(r_blen)) begin
            w_state_n  = S_DONE;
            w_app_en_n = 1'b0;
          end
        end
`ifdef RD_TIMEOUT_EN
        else if (r_tmo == {TMO_W{1'b1}}) begin
          w_state_n      = S_DONE;
          w_app_en_n     = 1'b0;
          w_rd_timeout_n = 1'b1;
        end else begin
          w_tmo_n = r_tmo + TMO_W'(1);
        end
`endif
      end

      S_DONE: begin
        w_state_n  = S_IDLE;
        w_cmptd_n  = 1'b1;
        w_app_en_n = 1'b0;
        w_wren_n   = 1'b0;
        w_wphase_n = WP_RUN;
      end

      default: begin
        w_state_n  = S_CALIB;
        w_app_en_n = 1'b0;
        w_wren_n   = 1'b0;
      end
    endcase
  end

  assign tg_state     = r_state;
  assign app_en       = r_app_en;
  assign app_cmd      = r_app_cmd;
  assign app_addr     = r_app_addr;
  assign app_wdf_wren = r_wren;
  assign app_wdf_end  = r_wren;
  assign app_wdf_data = r_wdf_data;
  assign app_wdf_mask = r_wdf_mask;
  assign wdata_next   = r_wdata_next;
  assign cmd_cmptd    = r_cmptd;
  assign rdata        = r_rdata;
  assign rdata_vld    = r_rdata_vld;
`ifdef RD_TIMEOUT_EN
  assign rd_timeout   = r_rd_timeout;
`endif

endmodule

// File: doc/ddr_cmd_engine.md
Name: ddr_cmd_engine

Overview:
- Command engine that receives single/burst read-write commands from the processor/boot-loader bridge and drives the MIG 7-series native app interface.
- Issues one 32-bit word per app transaction, with a byte mask selecting the lane. Returns read words in order.
- Reports progress to the upstream bridge through a one-hot tg_state bus and a cmd_cmptd pulse.
- Sits between the bridge and mig_7series_0.

Parameters:
- ADDR_W, 28: MIG app_addr width.
- APP_DATA_W, 128: MIG app data width (4 lanes of 32 bits).

Ports:
- clk  in  1  MIG ui_clk
- resetn  in  1  reset, synchronous, active-low
- cmd_vld  in  1  command strobe from upstream
- cmd  in  1  1 = write, 0 = read
- addr  in  32  byte address, word-aligned
- blen  in  8  beats minus 1 (0 = single beat)
- data_i  in  32  write data for the current beat
- wdata_next  out  1  pulse: current write word consumed, present the next one
- tg_state  out  8  one-hot state
- cmd_cmptd  out  1  pulse: ready for a new command
- rdata  out  32  read word
- rdata_vld  out  1  read word valid, one cycle
- init_calib_complete  in  1  from MIG
- app_en, app_cmd[2:0], app_addr[ADDR_W-1:0]  out  -  MIG command
- app_rdy  in  1  MIG command accept
- app_wdf_wren, app_wdf_end  out  1 each  MIG write data strobes
- app_wdf_data  out  APP_DATA_W  MIG write data
- app_wdf_mask  out  APP_DATA_W/8  MIG write byte mask
- app_wdf_rdy  in  1  MIG write data accept
- app_rd_data  in  APP_DATA_W  MIG read data
- app_rd_data_valid  in  1  MIG read data valid

Behaviour:
- **Reset.**
  - Reset values: tg_state = 0x01, all app_* strobes 0, app_cmd = 0, cmd_cmptd = 0, rdata_vld = 0, wdata_next = 0, rdata = 0, counters 0.
  - Reset mid-operation abandons the command immediately. No further MIG strobes are issued. Outstanding read returns are ignored until IDLE is re-entered.
- **States (tg_state encoding).**
  - CALIB 0x01: wait for init_calib_complete = 1. Then go to IDLE and pulse cmd_cmptd for one cycle.
  - IDLE 0x02: on cmd_vld = 1, capture addr, cmd, blen and data_i. Clear the beat counter bcnt. Go to WR 0x04 if cmd = 1, else RD 0x20.
  - WR 0x04:
    - Assert app_en = 1, app_cmd = 000, app_wdf_wren = 1, app_wdf_end = 1 together.
    - Hold the command half until app_rdy and the data half until app_wdf_rdy. Each half deasserts independently once accepted.
    - When both halves are accepted, that beat is done.
  - RD 0x20:
    - Issue app_en = 1, app_cmd = 001, held until app_rdy. One command per beat.
    - Count issued commands (icnt) and returned words (rcnt) separately.
    - Stop issuing when icnt = blen+1. Leave when rcnt = blen+1.
  - DONE 0x40: one cycle. Pulse cmd_cmptd, then return to IDLE.
- **Address mapping.**
  - app_addr = addr[ADDR_W:1] with bits [2:0] forced to 0.
  - Lane = addr[3:2].
  - Per beat, addr advances by 4 (32-bit add, wraps modulo 2^32). The lane and app_addr are recomputed from it.
- **Write data.**
  - app_wdf_data = word replicated in all four lanes.
  - app_wdf_mask = all 1s except the 4 bits of the selected lane, which are 0.
  - After each accepted beat except the last, pulse wdata_next for one cycle. The next data_i is sampled on the following cycle.
- **Read data.**
  - On app_rd_data_valid, rdata = the lane of app_rd_data selected by the return-side address counter. That counter starts at the captured addr and advances by 4 per word.
  - rdata_vld pulses for one cycle, registered (1-cycle latency).
- **cmd_vld handling.** cmd_vld is ignored outside IDLE. Upstream drops it on seeing tg_state 0x04 or 0x20.
- **Unexpected read data.** app_rd_data_valid outside RD is discarded.
- **Calibration loss.** If init_calib_complete falls while in IDLE, return to CALIB.

Optional Feature:
- Macro: RD_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter runs in RD. It resets on each returned word.
  - On reaching 0xFFFF it forces DONE, pulses cmd_cmptd and sets sticky output rd_timeout = 1.
  - rd_timeout is cleared only by reset.
- Without the macro: no counter, no rd_timeout port. RD waits indefinitely.

Test Plan:
- Calibration: hold init_calib_complete = 0 for 50 cycles, then 1 → tg_state 0x01, then 0x02 with one cmd_cmptd pulse.
- Single write:
  - Stimulus: cmd = 1, addr = 0x0000_0014, blen = 0, data_i = 0xDEADBEEF, with app_rdy = 1 and app_wdf_rdy delayed 3 cycles.
  - Expected: app_addr = 0x008, lane-1 mask = 0xFF0F, one app_wdf_wren accepted, no wdata_next, tg_state 0x04 → 0x40 → 0x02.
- Burst read:
  - Stimulus: cmd = 0, addr = 0x0000_0000, blen = 7, model returns words with 2-cycle latency.
  - Expected: 8 app_en accepts, app_addr 0x000 ×4 then 0x008 ×4, 8 rdata_vld pulses with lanes 0,1,2,3,0,1,2,3, cmd_cmptd after the 8th.
- Burst write with app_rdy toggling: blen = 3 → exactly 4 command and 4 data accepts, 3 wdata_next pulses.
- Reset mid-burst: deassert resetn during beat 2 of a 4-beat read → next cycle all app strobes 0, tg_state 0x01, stale read returns produce no rdata_vld.
- RD_TIMEOUT_EN: read with no return data → after 65535 cycles, rd_timeout = 1, cmd_cmptd pulses, tg_state returns to 0x02.
